// File: rtl/autocorr_sequencer.sv
// Autocorrelation sequencer: captures a FRAME_LEN-bit serial frame, then emits
// one match count per lag 0..LAG_MAX over a valid/ready result stream.
module autocorr_sequencer #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned LAG_MAX   = 7,
  localparam int unsigned CW = $clog2(FRAME_LEN + 1),
  localparam int unsigned LW = (LAG_MAX > 0) ? $clog2(LAG_MAX + 1) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          in_i,
  input  logic          in_valid_i,
  output logic          busy_o,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [LW-1:0] res_lag_o,
  output logic [CW-1:0] res_match_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_EMIT    = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic [LW-1:0]        lag_q, lag_d;
  logic [CW-1:0]        match_q, match_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 accept;

  // Number of positions i where f[i] == f[i+lag], over the overlapping span only.
  function automatic logic [CW-1:0] match_count(input logic [FRAME_LEN-1:0] f,
                                                input logic [LW-1:0]        lag);
    logic [FRAME_LEN-1:0] ones;
    logic [FRAME_LEN-1:0] eq;
    logic [CW-1:0]        n;
    ones = '1;
    eq   = ~(f ^ (f >> lag)) & (ones >> lag);
    n    = '0;
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      n = n + CW'(eq[i]);
    end
    return n;
  endfunction

  assign accept = valid_q & res_ready_i;

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      lag_q   <= '0;
      match_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      lag_q   <= lag_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state, capture/sweep bookkeeping and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    lag_d   = lag_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        if (in_valid_i) begin
          for (int i = 0; i < int'(FRAME_LEN); i++) begin
            if (cnt_q == CW'(i)) frame_d[i] = in_i;
          end
          if (cnt_q == CW'(FRAME_LEN - 1)) begin
            state_d = S_EMIT;
            cnt_d   = '0;
            lag_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_EMIT: begin
        if (accept) begin
          if (lag_q == LW'(LAG_MAX)) begin
            state_d = S_DONE;
          end else begin
            lag_d = lag_q + LW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything above, including start and the final accept.
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lag_d   = '0;
    end

    // Lag only carries meaning while results are being emitted.
    if (state_d != S_EMIT) lag_d = '0;

    busy_d  = (state_d == S_CAPTURE) || (state_d == S_EMIT);
    valid_d = (state_d == S_EMIT);
    done_d  = (state_d == S_DONE);
    match_d = valid_d ? match_count(frame_d, lag_d) : '0;
  end

  assign busy_o      = busy_q;
  assign res_valid_o = valid_q;
  assign res_lag_o   = lag_q;
  assign res_match_o = match_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_autocorr_sequencer.sv
// Scoreboard bench for autocorr_sequencer: driver pushes expected lag/match
// pairs from a bit-level reference model; a negedge monitor pops on accept.
module tb_autocorr_sequencer;

  localparam int unsigned FL = 8;
  localparam int unsigned LM = 7;
  localparam int unsigned CW = $clog2(FL + 1);
  localparam int unsigned LW = (LM > 0) ? $clog2(LM + 1) : 1;

  typedef struct {
    int lag;
    int m;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_b = 1'b0;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b1;
  logic          busy_o;
  logic          res_valid_o;
  logic [LW-1:0] res_lag_o;
  logic [CW-1:0] res_match_o;
  logic          done_o;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;
  int   stall_cnt = 0;
  int   stall_seen = 0;
  bit   last_acc = 1'b0;

  autocorr_sequencer #(.FRAME_LEN(FL), .LAG_MAX(LM)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .in_i        (in_b),
    .in_valid_i  (in_valid),
    .busy_o      (busy_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready),
    .res_lag_o   (res_lag_o),
    .res_match_o (res_match_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count pairs (i, i+lag) inside the frame holding equal bits.
  task automatic push_expect(input logic [FL-1:0] f);
    exp_t e;
    for (int lag = 0; lag <= int'(LM); lag++) begin
      int m;
      m = 0;
      for (int i = 0; i + lag < int'(FL); i++) begin
        if (f[i] == f[i + lag]) m++;
      end
      e.lag = lag;
      e.m   = m;
      q.push_back(e);
    end
  endtask

  // Consumer ready: always, random, or a 5-cycle hold at lag 3.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: res_ready = 1'($urandom_range(0, 1));
      2: begin
        if (res_valid_o && int'(res_lag_o) == 3 && stall_cnt < 5) begin
          res_ready = 1'b0;
          stall_cnt++;
        end else begin
          res_ready = 1'b1;
        end
      end
      default: res_ready = 1'b1;
    endcase
  end

  // Monitor: compare accepted results, stalled-result stability and done timing.
  always @(negedge clk) begin
    if (rst) begin
      last_acc = 1'b0;
    end else begin
      bit exp_done;
      exp_done = last_acc;
      last_acc = 1'b0;
      if (done_o || exp_done) chk("done_pulse", int'(done_o), int'(exp_done));
      if (res_valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else if (res_ready) begin
          exp_t e;
          e = q.pop_front();
          chk("res_lag", int'(res_lag_o), e.lag);
          chk("res_match", int'(res_match_o), e.m);
          last_acc = (e.lag == int'(LM)) && !abort;
        end else begin
          stall_seen++;
          chk("stall_lag", int'(res_lag_o), q[0].lag);
          chk("stall_match", int'(res_match_o), q[0].m);
        end
      end
    end
  end

  // Start, then feed bits with random gaps; optional start noise and abort on bit abort_at.
  task automatic feed(input logic [FL-1:0] f, input int gap_pct, input bit noise,
                      input int abort_at, output bit aborted);
    int i;
    aborted  = 1'b0;
    start    = 1'b1;
    in_valid = 1'($urandom);
    in_b     = 1'($urandom);
    tick();
    start = 1'b0;
    i = 0;
    while (i < int'(FL) && !aborted) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        in_b     = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_b     = f[i];
        if (i == abort_at) begin
          abort   = 1'b1;
          aborted = 1'b1;
        end
        i++;
      end
      start = noise && ($urandom_range(0, 3) == 0);
      if (i == int'(FL) && !aborted) push_expect(f);
      tick();
      abort = 1'b0;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int ncyc);
    bit got;
    got  = 1'b0;
    ncyc = 0;
    while (ncyc < 400 && !got) begin
      start = noise && res_valid_o && ($urandom_range(0, 3) == 0);
      tick();
      ncyc++;
      if (done_o) got = 1'b1;
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    tick();
    chk("done_one_cycle", int'(done_o), 0);
    chk("idle_busy", int'(busy_o), 0);
  endtask

  task automatic run_frame(input logic [FL-1:0] f, input int gap_pct, input bit noise,
                           input int exp_cyc);
    bit ab;
    int n;
    feed(f, gap_pct, noise, -1, ab);
    wait_done(noise, n);
    if (exp_cyc > 0) chk("latency_cycles", n, exp_cyc);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    bit ab;
    int n;
    logic [FL-1:0] rf;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_valid", int'(res_valid_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_lag", int'(res_lag_o), 0);
    chk("rst_match", int'(res_match_o), 0);
    rst = 1'b0;
    tick();

    // Idle ignores serial input.
    in_valid = 1'b1;
    in_b     = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("idle_ignores_in", int'(busy_o), 0);

    // Bits 1,0,1,1,0,0,1,0 (first bit is frame[0]), ready always high.
    rdy_mode = 0;
    run_frame(8'h4D, 0, 1'b0, 8);
    // All ones and alternating.
    run_frame(8'hFF, 0, 1'b0, 8);
    run_frame(8'h55, 0, 1'b0, 8);

    // Hold ready low for 5 cycles at lag 3.
    rdy_mode   = 2;
    stall_cnt  = 0;
    stall_seen = 0;
    run_frame(8'h4D, 0, 1'b0, 13);
    chk("stall_cycles", stall_seen, 5);
    rdy_mode = 0;

    // Random frames with in_valid gaps, start noise and random ready.
    for (int k = 0; k < 12; k++) begin
      rdy_mode = (k % 2 == 0) ? 1 : 0;
      rf = FL'($urandom);
      run_frame(rf, 40, 1'b1, 0);
    end
    rdy_mode = 0;

    // Abort on the 4th captured bit, then a fresh frame.
    feed(8'h4D, 0, 1'b0, 3, ab);
    chk("abort_cap_flag", int'(ab), 1);
    chk("abort_cap_busy", int'(busy_o), 0);
    chk("abort_cap_valid", int'(res_valid_o), 0);
    repeat (3) tick();
    run_frame(8'h4D, 0, 1'b0, 8);

    // Abort together with the lag-5 accept.
    feed(8'h4D, 0, 1'b0, -1, ab);
    n = 0;
    while (n < 50 && !(res_valid_o && int'(res_lag_o) == 5)) begin
      tick();
      n++;
    end
    chk("reach_lag5", int'(res_lag_o), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_emit_valid", int'(res_valid_o), 0);
    chk("abort_emit_busy", int'(busy_o), 0);
    chk("abort_emit_left", q.size(), 2);
    q.delete();
    repeat (4) tick();
    run_frame(8'h4D, 0, 1'b0, 8);

    // Reset in the middle of EMIT.
    feed(8'hFF, 0, 1'b0, -1, ab);
    n = 0;
    while (n < 50 && !(res_valid_o && int'(res_lag_o) == 2)) begin
      tick();
      n++;
    end
    chk("reach_lag2", int'(res_lag_o), 2);
    rst = 1'b1;
    tick();
    chk("rst_emit_busy", int'(busy_o), 0);
    chk("rst_emit_valid", int'(res_valid_o), 0);
    chk("rst_emit_done", int'(done_o), 0);
    chk("rst_emit_lag", int'(res_lag_o), 0);
    chk("rst_emit_match", int'(res_match_o), 0);
    rst = 1'b0;
    q.delete();
    tick();
    run_frame(8'h4D, 0, 1'b0, 8);

    repeat (3) tick();
    chk("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
